score_reader: RTL and testbench



---
 rtl/score_reader.sv | 181 ++++++++++++++++++
 tb/tb_score_reader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_reader.sv
`timescale 1ns/1ps
// score_reader
// Latches a scored three-position guess (H2/H1/H0), then presents each hint
// on the display bus for DWELL cycles, in the order N2, N1, N0. After the
// display it evaluates the guess: three exact hints win the game, and using
// up MAX_ATTEMPTS guesses without a win loses it. WON and LOST hold until
// NEW_GAME is asserted.
//
// Optional feature: define macro STREAK_EN to keep a saturating count of
// consecutive won games on WIN_STREAK. Without it, WIN_STREAK is tied to 0.
//
// Ports
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   START      in   one-cycle pulse: H2/H1/H0 hold a scored guess
//   H2,H1,H0   in   hint per position (10 exact, 01 present, 00/11 absent)
//   NEW_GAME   in   abandon or finish the game, return to IDLE
//   DISP_HINT  out  hint currently presented
//   DISP_SEL   out  position presented (10 N2, 11 N1, 01 N0, 00 none)
//   DISP_VALID out  DISP_HINT/DISP_SEL are meaningful
//   BUSY       out  display or evaluation in progress
//   WIN, LOSE  out  game won / game lost
//   ATTEMPTS   out  guesses scored in the current game
//   WIN_STREAK out  consecutive wins (STREAK_EN only, else 0)
module score_reader #(
  parameter int DWELL        = 4,
  parameter int MAX_ATTEMPTS = 6
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [1:0] H2,
  input  logic [1:0] H1,
  input  logic [1:0] H0,
  input  logic       NEW_GAME,
  output logic [1:0] DISP_HINT,
  output logic [1:0] DISP_SEL,
  output logic       DISP_VALID,
  output logic       BUSY,
  output logic       WIN,
  output logic       LOSE,
  output logic [2:0] ATTEMPTS,
  output logic [3:0] WIN_STREAK
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [2:0] MAX_A      = 3'(MAX_ATTEMPTS);
  localparam logic [1:0] EXACT      = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_SHOW_N2, S_SHOW_N1, S_SHOW_N0, S_EVAL, S_WON, S_LOST
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] dwell_reg;
  logic [2:0] attempts_reg;
  logic [1:0] hint_reg [3];  // index 2 = N2, 1 = N1, 0 = N0
  logic [1:0] hint_in  [3];

  logic       dwell_done;
  logic       all_exact;
  logic [2:0] att_inc;

  assign hint_in[2] = H2;
  assign hint_in[1] = H1;
  assign hint_in[0] = H0;

  assign dwell_done = (dwell_reg == DWELL_LAST);
  assign all_exact  = (hint_reg[2] == EXACT) && (hint_reg[1] == EXACT) &&
                      (hint_reg[0] == EXACT);
  assign att_inc    = (attempts_reg == MAX_A) ? MAX_A : attempts_reg + 3'd1;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; NEW_GAME overrides everything, including START in IDLE
  always_comb begin
    state_next = state_reg;
    if (NEW_GAME) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:    if (START)      state_next = S_SHOW_N2;
        S_SHOW_N2: if (dwell_done) state_next = S_SHOW_N1;
        S_SHOW_N1: if (dwell_done) state_next = S_SHOW_N0;
        S_SHOW_N0: if (dwell_done) state_next = S_EVAL;
        // A win on the last allowed attempt must still report WON
        S_EVAL:    state_next = all_exact ? S_WON :
                                (att_inc == MAX_A) ? S_LOST : S_IDLE;
        S_WON:     state_next = S_WON;
        S_LOST:    state_next = S_LOST;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // Output logic: purely from registered state, so no input-to-output paths
  always_comb begin
    DISP_VALID = 1'b0;
    DISP_SEL   = 2'b00;
    DISP_HINT  = 2'b00;
    BUSY       = 1'b0;
    WIN        = 1'b0;
    LOSE       = 1'b0;
    case (state_reg)
      S_SHOW_N2: begin DISP_VALID = 1'b1; DISP_SEL = 2'b10; DISP_HINT = hint_reg[2]; BUSY = 1'b1; end
      S_SHOW_N1: begin DISP_VALID = 1'b1; DISP_SEL = 2'b11; DISP_HINT = hint_reg[1]; BUSY = 1'b1; end
      S_SHOW_N0: begin DISP_VALID = 1'b1; DISP_SEL = 2'b01; DISP_HINT = hint_reg[0]; BUSY = 1'b1; end
      S_EVAL:    BUSY = 1'b1;
      S_WON:     WIN  = 1'b1;
      S_LOST:    LOSE = 1'b1;
      default:   ;
    endcase
  end

  assign ATTEMPTS = attempts_reg;

  // Dwell counter restarts on every state change so each SHOW state lasts
  // exactly DWELL cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dwell_reg <= 8'd0;
    end else if (NEW_GAME || (state_next != state_reg)) begin
      dwell_reg <= 8'd0;
    end else if ((state_reg == S_SHOW_N2) || (state_reg == S_SHOW_N1) ||
                 (state_reg == S_SHOW_N0)) begin
      dwell_reg <= dwell_reg + 8'd1;
    end
  end

  // Hints are captured only on an accepted START, so later input changes
  // cannot disturb the display or the evaluation
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hint
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          hint_reg[gi] <= 2'b00;
        end else if (NEW_GAME) begin
          hint_reg[gi] <= 2'b00;
        end else if ((state_reg == S_IDLE) && START) begin
          hint_reg[gi] <= hint_in[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      attempts_reg <= 3'd0;
    end else if (NEW_GAME) begin
      attempts_reg <= 3'd0;
    end else if (state_reg == S_EVAL) begin
      attempts_reg <= att_inc;
    end
  end

`ifdef STREAK_EN
  // Streak survives NEW_GAME; only a lost game or reset clears it
  logic [3:0] streak_reg;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      streak_reg <= 4'd0;
    end else if (state_reg == S_EVAL) begin
      if (state_next == S_WON) begin
        if (streak_reg != 4'd15) streak_reg <= streak_reg + 4'd1;
      end else if (state_next == S_LOST) begin
        streak_reg <= 4'd0;
      end
    end
  end

  assign WIN_STREAK = streak_reg;
`else
  assign WIN_STREAK = 4'b0000;
`endif

endmodule

// File: tb/tb_score_reader.sv
`timescale 1ns/1ps
// Scoreboard bench for score_reader. The driver updates a game-level model
// (attempt count, game over flag, streak) and queues the expected display
// and outcome of every accepted guess; an independent monitor pops an entry
// whenever the DUT starts a display and checks it cycle by cycle.
module tb_score_reader;

  localparam int DWELL = 4;
  localparam int MAX   = 6;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       START = 1'b0;
  logic       NEW_GAME = 1'b0;
  logic [1:0] H2 = 2'b00, H1 = 2'b00, H0 = 2'b00;
  logic [1:0] DISP_HINT, DISP_SEL;
  logic       DISP_VALID, BUSY, WIN, LOSE;
  logic [2:0] ATTEMPTS;
  logic [3:0] WIN_STREAK;

  always #5 CLK = ~CLK;

  score_reader #(.DWELL(DWELL), .MAX_ATTEMPTS(MAX)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .H2(H2), .H1(H1), .H0(H0), .NEW_GAME(NEW_GAME),
    .DISP_HINT(DISP_HINT), .DISP_SEL(DISP_SEL), .DISP_VALID(DISP_VALID),
    .BUSY(BUSY), .WIN(WIN), .LOSE(LOSE),
    .ATTEMPTS(ATTEMPTS), .WIN_STREAK(WIN_STREAK)
  );

  typedef struct {
    logic [1:0] h2, h1, h0;
    int         ncyc;    // display cycles expected before it stops
    bit         full;    // display runs to completion and is evaluated
    int         att;
    bit         win;
    bit         lose;
    int         streak;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Game-level reference model
  int m_att = 0;
  int m_over = 0;      // 0 playing, 1 won, 2 lost
  int m_streak = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] rnd_miss_pos();
    logic [1:0] v;
    v = 2'($urandom);
    if (v == 2'b10) v = 2'b11;
    return v;
  endfunction

  task automatic play(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    exp_t e;
    bit   acc;
    @(negedge CLK);
    RST_N = 1'b1;
    START = 1'b1;
    H2 = a; H1 = b; H0 = c;
    acc = (m_over == 0);
    if (acc) begin
      m_att = (m_att < MAX) ? m_att + 1 : MAX;
      if (a == 2'b10 && b == 2'b10 && c == 2'b10) begin
        m_over = 1;
`ifdef STREAK_EN
        m_streak = (m_streak < 15) ? m_streak + 1 : 15;
`endif
      end else if (m_att == MAX) begin
        m_over = 2;
        m_streak = 0;
      end
      e.h2 = a; e.h1 = b; e.h0 = c;
      e.ncyc = 3 * DWELL; e.full = 1'b1;
      e.att = m_att; e.win = (m_over == 1); e.lose = (m_over == 2);
      e.streak = m_streak;
      exp_q.push_back(e);
    end
    $display("guess %b/%b/%b accepted=%0d model_att=%0d over=%0d streak=%0d",
             a, b, c, acc, m_att, m_over, m_streak);
    @(negedge CLK);
    START = 1'b0;
    H2 = 2'($urandom); H1 = 2'($urandom); H0 = 2'($urandom);
    if (!acc) chk("ignored_start_busy", BUSY, 0);
    repeat (3 * DWELL + 1) @(negedge CLK);
    if (!acc) begin
      chk("held_win", WIN, (m_over == 1) ? 1 : 0);
      chk("held_lose", LOSE, (m_over == 2) ? 1 : 0);
      chk("held_attempts", ATTEMPTS, m_att);
    end
  endtask

  task automatic play_miss();
    play(2'($urandom), 2'($urandom), rnd_miss_pos());
  endtask

  task automatic new_game();
    @(negedge CLK);
    NEW_GAME = 1'b1;
    m_att = 0; m_over = 0;
    @(negedge CLK);
    NEW_GAME = 1'b0;
    $display("new_game");
    chk("ng_attempts", ATTEMPTS, 0);
    chk("ng_win", WIN, 0);
    chk("ng_lose", LOSE, 0);
    chk("ng_busy", BUSY, 0);
    chk("ng_streak", WIN_STREAK, m_streak);
  endtask

  // Display aborted by NEW_GAME during display cycle k
  task automatic play_abort(input int k);
    exp_t e;
    @(negedge CLK);
    START = 1'b1;
    H2 = 2'b10; H1 = 2'b01; H0 = 2'b11;
    e.h2 = H2; e.h1 = H1; e.h0 = H0;
    e.ncyc = k; e.full = 1'b0; e.att = 0; e.win = 1'b0; e.lose = 1'b0; e.streak = 0;
    exp_q.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    repeat (k - 1) @(negedge CLK);
    NEW_GAME = 1'b1;
    m_att = 0; m_over = 0;
    @(negedge CLK);
    NEW_GAME = 1'b0;
    $display("abort at display cycle %0d", k);
    repeat (2) @(negedge CLK);
  endtask

  task automatic start_with_new_game();
    @(negedge CLK);
    START = 1'b1; NEW_GAME = 1'b1;
    H2 = 2'b10; H1 = 2'b10; H0 = 2'b10;
    m_att = 0; m_over = 0;
    @(negedge CLK);
    START = 1'b0; NEW_GAME = 1'b0;
    $display("start with new_game");
    chk("start_ng_busy", BUSY, 0);
    chk("start_ng_valid", DISP_VALID, 0);
    repeat (2) @(negedge CLK);
  endtask

  // Reset asserted during the first cycle of SHOW_N1
  task automatic reset_mid_n1();
    exp_t e;
    @(negedge CLK);
    START = 1'b1;
    H2 = 2'b01; H1 = 2'b10; H0 = 2'b00;
    e.h2 = H2; e.h1 = H1; e.h0 = H0;
    e.ncyc = DWELL + 1; e.full = 1'b0; e.att = 0; e.win = 1'b0; e.lose = 1'b0; e.streak = 0;
    exp_q.push_back(e);
    @(negedge CLK);
    START = 1'b0;
    repeat (DWELL) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    $display("reset during SHOW_N1");
    chk("rst_disp_valid", DISP_VALID, 0);
    chk("rst_disp_sel", DISP_SEL, 0);
    chk("rst_disp_hint", DISP_HINT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_win", WIN, 0);
    chk("rst_lose", LOSE, 0);
    chk("rst_attempts", ATTEMPTS, 0);
    chk("rst_streak", WIN_STREAK, 0);
    m_att = 0; m_over = 0; m_streak = 0;
    repeat (2) @(negedge CLK);
  endtask

  // Monitor
  initial begin
    exp_t       e;
    int         pos;
    logic [1:0] es, eh;
    forever begin
      @(negedge CLK);
      if (DISP_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_display: sel=%b hint=%b with no queued guess at %0t",
                   DISP_SEL, DISP_HINT, $time);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < e.ncyc; i++) begin
            if (i > 0) @(negedge CLK);
            pos = i / DWELL;
            es = (pos == 0) ? 2'b10 : (pos == 1) ? 2'b11 : 2'b01;
            eh = (pos == 0) ? e.h2 : (pos == 1) ? e.h1 : e.h0;
            chk("disp_valid", DISP_VALID, 1);
            chk("disp_sel", DISP_SEL, es);
            chk("disp_hint", DISP_HINT, eh);
            chk("busy_show", BUSY, 1);
          end
          @(negedge CLK);
          if (e.full) begin
            chk("eval_busy", BUSY, 1);
            chk("eval_valid", DISP_VALID, 0);
            chk("eval_sel", DISP_SEL, 0);
            @(negedge CLK);
            chk("result_win", WIN, e.win);
            chk("result_lose", LOSE, e.lose);
            chk("result_attempts", ATTEMPTS, e.att);
            chk("result_streak", WIN_STREAK, e.streak);
            chk("result_busy", BUSY, 0);
          end else begin
            chk("abort_valid", DISP_VALID, 0);
            chk("abort_busy", BUSY, 0);
            chk("abort_attempts", ATTEMPTS, 0);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver
  initial begin
    int r;
    #1 RST_N = 1'b0;
    #2;
    chk("reset_disp_valid", DISP_VALID, 0);
    chk("reset_disp_sel", DISP_SEL, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_win", WIN, 0);
    chk("reset_lose", LOSE, 0);
    chk("reset_attempts", ATTEMPTS, 0);
    chk("reset_streak", WIN_STREAK, 0);
    repeat (2) @(negedge CLK);

    // First guess issued in the same cycle reset is released
    play(2'b10, 2'b01, 2'b00);
    play(2'b10, 2'b10, 2'b10);
    play(2'b01, 2'b10, 2'b10);
    new_game();

    repeat (5) play_miss();
    play(2'b10, 2'b10, 2'b10);
    new_game();

    repeat (6) play_miss();
    play_miss();
    new_game();

    play_abort(6);
    start_with_new_game();

    play(2'b10, 2'b10, 2'b10);
    new_game();
    play(2'b10, 2'b10, 2'b10);
    new_game();
    repeat (6) play_miss();
    new_game();

    play(2'b10, 2'b10, 2'b10);
    new_game();
    play_miss();
    reset_mid_n1();
    play_miss();

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      new_game();
      else if (r <= 2) play(2'b10, 2'b10, 2'b10);
      else             play(2'($urandom), 2'($urandom), 2'($urandom));
    end

    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
